stream_pattern_matcher: RTL and testbench
=========================================

# stream_pattern_matcher

Parametrised streaming byte-pattern detector for the packet datapath. It compares a masked pattern of `PATTERN_BYTES` bytes against every byte offset of a framed `DATA_WIDTH` stream, including matches that straddle two beats. Each byte offset is checked exactly once per packet, and matches never cross packet boundaries. It reports per-match position, a per-packet verdict and a running match count.

## Interface
- `DATA_WIDTH`, 64: beat width in bits; multiple of 8, at least 16.
- `PATTERN_BYTES`, 7: pattern length; 1 to `DATA_WIDTH/8`.
- `OFFSET_WIDTH`, 16: width of the byte offset and count outputs.

- `clock`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `data_in`, in, `DATA_WIDTH`: beat; byte 0 is `data_in[DATA_WIDTH-1 -: 8]`.
- `data_valid_in`, in, 1: beat qualifier.
- `sop_in`, in, 1: first beat of packet; qualified by valid.
- `eop_in`, in, 1: last beat of packet; qualified by valid.
- `pattern_in`, in, `PATTERN_BYTES*8`: pattern, byte 0 in the MSBs.
- `pattern_mask_in`, in, `PATTERN_BYTES`: 1 = byte must match; 0 = wildcard. The MSB corresponds to pattern byte 0.
- `clear_count_in`, in, 1: synchronous clear of `match_count_o`.
- `match_o`, out, 1: one-cycle pulse, at least one match ended in a beat.
- `match_offset_o`, out, `OFFSET_WIDTH`: packet byte offset of the lowest match start in that beat.
- `pkt_done_o`, out, 1: one-cycle pulse per completed packet.
- `pkt_match_o`, out, 1: valid with `pkt_done_o`; 1 if the packet had any match.
- `match_count_o`, out, `OFFSET_WIDTH`: total matches since reset or clear; saturating.

## Operation
- FSM states:
  - `IDLE`: beats without `sop_in` are ignored.
  - `ACTIVE`: inside a packet.
  - `IDLE`→`ACTIVE` on a valid `sop_in`.
  - `ACTIVE`→`IDLE` on a valid `eop_in`.
  - `sop_in && eop_in` on the same beat is a single-beat packet and leaves the state in `IDLE`.
- A valid `sop_in` while `ACTIVE` aborts the current packet: no `pkt_done_o` for it, and a new packet starts.
- `pattern_in` and `pattern_mask_in` are latched on the sop beat and held for the whole packet. Changes mid-packet have no effect.
- Stage 1, on each valid beat: window ← {previous beat, current beat}. The previous-beat half is marked invalid on a sop beat.
- Stage 2 evaluates `DATA_WIDTH/8` candidate positions: exactly those whose last pattern byte lies in the current beat. This gives no duplicates and no misses.
- A candidate that reaches into an invalid previous half is suppressed. Straddles are therefore only possible within one packet.
- Each position matches if every mask=1 byte is equal. An all-zero mask never matches.
- Byte offset counter: 0 at sop, +`DATA_WIDTH/8` per valid beat, saturates. `match_offset_o` = start-byte offset of the lowest matching position.
- `match_count_o` adds the number of matching positions in the beat, saturating at all-ones. `clear_count_in` has priority over the increment in the same cycle.
- `data_valid_in` low is a bubble: no shift, no compare, state held.

## Timing
- Reset values: all outputs 0, FSM `IDLE`, window invalid, counters 0.
- `match_o` and `match_offset_o` assert 2 cycles after the valid beat containing the last matched byte, with registered outputs. `match_count_o` shows the new value in that same cycle.
- `pkt_done_o` and `pkt_match_o` assert 2 cycles after the eop beat. `pkt_match_o` includes any match reported for the eop beat itself.
- Back-to-back beats are accepted every cycle; throughput is 1 beat/cycle.
- Asserting reset mid-packet drops all in-flight results. The first valid sop after reset deasserts is processed normally.

## Structure
- Shared package `pattern_match_pkg`:
  - FSM state encoding (`IDLE`, `ACTIVE`).
  - `BYTE_W = 8`.
  - Function that computes the candidate count from `DATA_WIDTH`.
- One sub-module, `masked_window_compare`: one candidate position, a combinational masked byte-wise equality over `PATTERN_BYTES`. It is generated `DATA_WIDTH/8` times.
- Top level holds the FSM, the window registers, the offset and count counters, and priority encoding of the lowest match.

## Test plan
All scenarios use `DATA_WIDTH`=64, `PATTERN_BYTES`=7, pattern 0x11223344556677, mask 7'h7F unless noted.

- **Single-beat packet:** sop+eop beat 0x11223344556677AA → `match_o` at T+2, offset 0, `pkt_match_o`=1, count=1.
- **Straddle:** beat0 bytes 5..7 = 11 22 33, beat1 bytes 0..3 = 44 55 66 77 → one `match_o` after beat1, offset 5. No repeat match after beat2.
- **Packet boundary:** pattern head at the end of packet A (eop), tail at the start of packet B (sop) → no match; `pkt_match_o`=0 for both packets.
- **Wildcard:** mask 7'b1110111, data byte 3 = 0xFF instead of 0x44 → match reported. With mask 0 → no match ever.
- **Bubbles and abort:** straddle case with valid low for 3 cycles between the beats → still one match. A new sop mid-packet → no `pkt_done_o` for the aborted packet. Reset pulse mid-packet → all outputs 0, and the next packet matches normally.
- **Counter:** a beat of repeated 0x11 with pattern 0x11111111111111 → count +8 in one beat. Count saturates at 0xFFFF. `clear_count_in` together with a match gives count=0.

Source files
------------

// File: rtl/stream_pattern_matcher_pkg.sv
// pattern_match_pkg: shared constants, FSM encoding and sizing helper for stream_pattern_matcher
package pattern_match_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    function automatic int cand_count(input int data_width);
        return data_width / BYTE_W;
    endfunction
endpackage

// File: rtl/stream_pattern_matcher_if.sv
// stream_pattern_matcher_if: framed byte stream in, match/packet results out
//   master: drives data/valid/sop/eop, pattern, mask and count clear; reads the results
//   slave:  the matcher; reads the stream and drives match, offset, packet verdict and count
interface stream_pattern_matcher_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int PATTERN_BYTES = 7,
    parameter int OFFSET_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0]      data_in;
    logic                       data_valid_in;
    logic                       sop_in;
    logic                       eop_in;
    logic [PATTERN_BYTES*8-1:0] pattern_in;
    logic [PATTERN_BYTES-1:0]   pattern_mask_in;
    logic                       clear_count_in;
    logic                       match_o;
    logic [OFFSET_WIDTH-1:0]    match_offset_o;
    logic                       pkt_done_o;
    logic                       pkt_match_o;
    logic [OFFSET_WIDTH-1:0]    match_count_o;
    modport master (
        output data_in, data_valid_in, sop_in, eop_in, pattern_in, pattern_mask_in, clear_count_in,
        input  match_o, match_offset_o, pkt_done_o, pkt_match_o, match_count_o
    );
    modport slave (
        input  data_in, data_valid_in, sop_in, eop_in, pattern_in, pattern_mask_in, clear_count_in,
        output match_o, match_offset_o, pkt_done_o, pkt_match_o, match_count_o
    );
endinterface

// File: rtl/stream_pattern_matcher_compare.sv
// masked_window_compare: masked byte-wise equality of one candidate window against the pattern
//   window_i/pattern_i: PATTERN_BYTES bytes, byte 0 in the MSBs
//   mask_i: 1 = byte must match, MSB is byte 0; match_o: all masked bytes equal and mask non-zero
module masked_window_compare
    import pattern_match_pkg::*;
#(
    parameter int PATTERN_BYTES = 7
) (
    input  logic [PATTERN_BYTES*BYTE_W-1:0] window_i,
    input  logic [PATTERN_BYTES*BYTE_W-1:0] pattern_i,
    input  logic [PATTERN_BYTES-1:0]        mask_i,
    output logic                            match_o
);
    always_comb begin
        match_o = |mask_i;
        for (int j = 0; j < PATTERN_BYTES; j++)
            if (mask_i[PATTERN_BYTES-1-j] &&
                window_i[(PATTERN_BYTES-j)*BYTE_W-1 -: BYTE_W] != pattern_i[(PATTERN_BYTES-j)*BYTE_W-1 -: BYTE_W])
                match_o = 1'b0;
    end
endmodule

// File: rtl/stream_pattern_matcher.sv
// stream_pattern_matcher: masked pattern search over every byte offset of a framed stream
//   clock/reset: single clock, asynchronous active-high reset
//   bus (slave): stream, pattern and mask in; match pulse/offset, packet verdict and
//   saturating match count out, all registered two cycles after the beat
module stream_pattern_matcher
    import pattern_match_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int PATTERN_BYTES = 7,
    parameter int OFFSET_WIDTH  = 16
) (
    input logic                    clock,
    input logic                    reset,
    stream_pattern_matcher_if.slave bus
);
    localparam int NB    = cand_count(DATA_WIDTH);
    localparam int PW    = PATTERN_BYTES * BYTE_W;
    localparam int DW2   = 2 * DATA_WIDTH;
    // window byte where candidate 0 starts; candidate k ends on current-beat byte k
    localparam int FIRST = NB - PATTERN_BYTES + 1;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   prev_q, cur_q;
    logic                    prev_ok_q, s1_vld_q, s1_sop_q, s1_eop_q, pkt_any_q;
    logic [OFFSET_WIDTH-1:0] off_q, s1_off_q;
    logic [PW-1:0]           pat_q;
    logic [PATTERN_BYTES-1:0] mask_q;
    logic                    match_q, done_q, pmatch_q;
    logic [OFFSET_WIDTH-1:0] moff_q, count_q;

    logic                    accept;
    logic [OFFSET_WIDTH-1:0] beat_off, off_d, moff_d, count_d;
    logic [OFFSET_WIDTH:0]   off_sum, sum_d;
    logic [DW2-1:0]          win;
    logic [NB-1:0]           hit;

    assign accept   = bus.data_valid_in && (bus.sop_in || state_q == ACTIVE);
    assign beat_off = bus.sop_in ? '0 : off_q;
    assign off_sum  = {1'b0, beat_off} + (OFFSET_WIDTH+1)'(NB);
    assign off_d    = off_sum[OFFSET_WIDTH] ? '1 : off_sum[OFFSET_WIDTH-1:0];
    assign win      = {prev_q, cur_q};

    for (genvar k = 0; k < NB; k++) begin : g_cand
        logic raw;
        masked_window_compare #(.PATTERN_BYTES(PATTERN_BYTES)) u_cmp (
            .window_i (win[DW2-1-(FIRST+k)*BYTE_W -: PW]),
            .pattern_i(pat_q),
            .mask_i   (mask_q),
            .match_o  (raw)
        );
        // candidates reaching into the previous beat need it to belong to this packet
        assign hit[k] = s1_vld_q && raw && (prev_ok_q || FIRST + k >= NB);
    end

    always_comb begin
        moff_d = '0;
        sum_d  = {1'b0, count_q};
        for (int k = NB - 1; k >= 0; k--)
            if (hit[k]) moff_d = s1_off_q + OFFSET_WIDTH'(k) - OFFSET_WIDTH'(PATTERN_BYTES - 1);
        for (int k = 0; k < NB; k++)
            sum_d = sum_d + (OFFSET_WIDTH+1)'(hit[k]);
        count_d = bus.clear_count_in ? '0 : sum_d[OFFSET_WIDTH] ? '1 : sum_d[OFFSET_WIDTH-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            cur_q     <= '0;
            prev_ok_q <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            s1_off_q  <= '0;
            off_q     <= '0;
            pat_q     <= '0;
            mask_q    <= '0;
            pkt_any_q <= 1'b0;
            match_q   <= 1'b0;
            moff_q    <= '0;
            done_q    <= 1'b0;
            pmatch_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (bus.data_valid_in)
                state_q <= bus.eop_in ? IDLE : bus.sop_in ? ACTIVE : state_q;
            s1_vld_q <= accept;
            if (accept) begin
                prev_q    <= cur_q;
                cur_q     <= bus.data_in;
                prev_ok_q <= !bus.sop_in;
                s1_sop_q  <= bus.sop_in;
                s1_eop_q  <= bus.eop_in;
                s1_off_q  <= beat_off;
                off_q     <= off_d;
            end
            if (accept && bus.sop_in) begin
                pat_q  <= bus.pattern_in;
                mask_q <= bus.pattern_mask_in;
            end
            if (s1_vld_q)
                pkt_any_q <= (pkt_any_q && !s1_sop_q) || |hit;
            match_q  <= |hit;
            moff_q   <= moff_d;
            done_q   <= s1_vld_q && s1_eop_q;
            pmatch_q <= s1_vld_q && s1_eop_q && ((pkt_any_q && !s1_sop_q) || |hit);
            count_q  <= count_d;
        end
    end

    assign bus.match_o        = match_q;
    assign bus.match_offset_o = moff_q;
    assign bus.pkt_done_o     = done_q;
    assign bus.pkt_match_o    = pmatch_q;
    assign bus.match_count_o  = count_q;
endmodule

// File: tb/tb_stream_pattern_matcher.sv
// tb_stream_pattern_matcher: directed scenarios with hand-computed expectations
module tb_stream_pattern_matcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    localparam logic [55:0] PAT = 56'h11223344556677;
    localparam logic [63:0] FULL = 64'h11223344556677AA;
    localparam logic [63:0] HEAD = 64'h0000000000112233;
    localparam logic [63:0] TAIL = 64'h4455667700000000;
    localparam logic [63:0] ONES = 64'h1111111111111111;

    always #5 clk = ~clk;

    stream_pattern_matcher_if #(.DATA_WIDTH(64), .PATTERN_BYTES(7), .OFFSET_WIDTH(16)) bus ();
    stream_pattern_matcher #(.DATA_WIDTH(64), .PATTERN_BYTES(7), .OFFSET_WIDTH(16)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    task automatic send(input logic [63:0] d, input logic s, input logic e);
        bus.data_in = d;
        bus.sop_in = s;
        bus.eop_in = e;
        bus.data_valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.data_valid_in = 1'b0;
        bus.sop_in = 1'b0;
        bus.eop_in = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if ({bus.match_o, bus.match_offset_o, bus.pkt_done_o, bus.pkt_match_o, bus.match_count_o} !== 35'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {bus.match_o, bus.match_offset_o, bus.pkt_done_o, bus.pkt_match_o, bus.match_count_o}); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_beat;
        send(FULL, 1'b1, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b1) begin failures++; $display("FAIL single_match got=%b exp=1", bus.match_o); end
        checks++; if (bus.match_offset_o !== 16'd0) begin failures++; $display("FAIL single_offset got=%0d exp=0", bus.match_offset_o); end
        checks++; if (bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b1) begin failures++; $display("FAIL single_pkt got=%b%b exp=11", bus.pkt_done_o, bus.pkt_match_o); end
        checks++; if (bus.match_count_o !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.match_count_o); end
        tick(1);
        checks++; if (bus.match_o !== 1'b0 || bus.pkt_done_o !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b%b exp=00", bus.match_o, bus.pkt_done_o); end
    endtask

    task automatic test_straddle;
        send(HEAD, 1'b1, 1'b0);
        bus.pattern_in = 56'd0;
        send(TAIL, 1'b0, 1'b0);
        checks++; if (bus.match_o !== 1'b0) begin failures++; $display("FAIL straddle_early got=%b exp=0", bus.match_o); end
        tick(1);
        checks++; if (bus.match_o !== 1'b1 || bus.match_offset_o !== 16'd5) begin failures++; $display("FAIL straddle_match got=%b/%0d exp=1/5", bus.match_o, bus.match_offset_o); end
        checks++; if (bus.match_count_o !== 16'd2) begin failures++; $display("FAIL straddle_count got=%0d exp=2", bus.match_count_o); end
        send(64'd0, 1'b0, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b0 || bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b1) begin failures++; $display("FAIL straddle_eop got=%b%b%b exp=011", bus.match_o, bus.pkt_done_o, bus.pkt_match_o); end
        bus.pattern_in = PAT;
    endtask

    task automatic test_boundary;
        send(64'd0, 1'b1, 1'b0);
        send(HEAD, 1'b0, 1'b1);
        send(TAIL, 1'b1, 1'b1);
        checks++; if (bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b0 || bus.match_o !== 1'b0) begin failures++; $display("FAIL boundary_a got=%b%b%b exp=100", bus.pkt_done_o, bus.pkt_match_o, bus.match_o); end
        tick(1);
        checks++; if (bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b0 || bus.match_o !== 1'b0) begin failures++; $display("FAIL boundary_b got=%b%b%b exp=100", bus.pkt_done_o, bus.pkt_match_o, bus.match_o); end
    endtask

    task automatic test_wildcard;
        bus.pattern_mask_in = 7'b1110111;
        send(64'h112233FF556677AA, 1'b1, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b1 || bus.match_offset_o !== 16'd0 || bus.pkt_match_o !== 1'b1) begin failures++; $display("FAIL wildcard_match got=%b/%0d/%b exp=1/0/1", bus.match_o, bus.match_offset_o, bus.pkt_match_o); end
        bus.pattern_mask_in = 7'd0;
        send(FULL, 1'b1, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b0 || bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b0) begin failures++; $display("FAIL mask_zero got=%b%b%b exp=010", bus.match_o, bus.pkt_done_o, bus.pkt_match_o); end
        bus.pattern_mask_in = 7'h7F;
    endtask

    task automatic test_bubbles;
        send(HEAD, 1'b1, 1'b0);
        tick(3);
        checks++; if (bus.match_o !== 1'b0) begin failures++; $display("FAIL bubble_idle got=%b exp=0", bus.match_o); end
        send(TAIL, 1'b0, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b1 || bus.match_offset_o !== 16'd5) begin failures++; $display("FAIL bubble_match got=%b/%0d exp=1/5", bus.match_o, bus.match_offset_o); end
        checks++; if (bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b1 || bus.match_count_o !== 16'd4) begin failures++; $display("FAIL bubble_pkt got=%b%b/%0d exp=11/4", bus.pkt_done_o, bus.pkt_match_o, bus.match_count_o); end
    endtask

    task automatic test_abort;
        send(FULL, 1'b1, 1'b0);
        send(TAIL, 1'b1, 1'b1);
        checks++; if (bus.match_o !== 1'b1 || bus.pkt_done_o !== 1'b0) begin failures++; $display("FAIL abort_first got=%b%b exp=10", bus.match_o, bus.pkt_done_o); end
        tick(1);
        checks++; if (bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b0 || bus.match_o !== 1'b0) begin failures++; $display("FAIL abort_second got=%b%b%b exp=100", bus.pkt_done_o, bus.pkt_match_o, bus.match_o); end
    endtask

    task automatic test_reset_mid;
        send(FULL, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if ({bus.match_o, bus.match_offset_o, bus.pkt_done_o, bus.pkt_match_o, bus.match_count_o} !== 35'd0) begin failures++; $display("FAIL reset_mid got=%h exp=0", {bus.match_o, bus.match_offset_o, bus.pkt_done_o, bus.pkt_match_o, bus.match_count_o}); end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++; if (bus.match_o !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", bus.match_o); end
        send(FULL, 1'b1, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b1 || bus.pkt_match_o !== 1'b1 || bus.match_count_o !== 16'd1) begin failures++; $display("FAIL reset_after got=%b%b/%0d exp=11/1", bus.match_o, bus.pkt_match_o, bus.match_count_o); end
    endtask

    task automatic test_counter;
        bus.pattern_in = 56'h11111111111111;
        bus.clear_count_in = 1'b1;
        tick(1);
        bus.clear_count_in = 1'b0;
        send(ONES, 1'b1, 1'b0);
        send(ONES, 1'b0, 1'b0);
        checks++; if (bus.match_count_o !== 16'd2 || bus.match_offset_o !== 16'd0) begin failures++; $display("FAIL count_first got=%0d/%0d exp=2/0", bus.match_count_o, bus.match_offset_o); end
        tick(1);
        checks++; if (bus.match_count_o !== 16'd10 || bus.match_offset_o !== 16'd2) begin failures++; $display("FAIL count_plus8 got=%0d/%0d exp=10/2", bus.match_count_o, bus.match_offset_o); end
        for (int i = 0; i < 8200; i++) send(ONES, 1'b0, i == 8199);
        tick(1);
        checks++; if (bus.match_count_o !== 16'hFFFF || bus.pkt_done_o !== 1'b1 || bus.pkt_match_o !== 1'b1) begin failures++; $display("FAIL count_sat got=%h/%b%b exp=ffff/11", bus.match_count_o, bus.pkt_done_o, bus.pkt_match_o); end
        bus.clear_count_in = 1'b1;
        send(ONES, 1'b1, 1'b1);
        tick(1);
        checks++; if (bus.match_o !== 1'b1 || bus.match_count_o !== 16'd0) begin failures++; $display("FAIL count_clear got=%b/%0d exp=1/0", bus.match_o, bus.match_count_o); end
        bus.clear_count_in = 1'b0;
        bus.pattern_in = PAT;
    endtask

    initial begin
        bus.data_in = '0;
        bus.data_valid_in = 1'b0;
        bus.sop_in = 1'b0;
        bus.eop_in = 1'b0;
        bus.pattern_in = PAT;
        bus.pattern_mask_in = 7'h7F;
        bus.clear_count_in = 1'b0;
        test_reset;
        test_single_beat;
        test_straddle;
        test_boundary;
        test_wildcard;
        test_bubbles;
        test_abort;
        test_reset_mid;
        test_counter;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
